// File: rtl/dm_responder.sv
// Single-port data memory responder: one request at a time, registered one-cycle response.
// Defining DM_WAIT_EN inserts WAIT_CYCLES wait states between acceptance and response.
module dm_responder #(
  parameter int DEPTH       = 3072,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        We,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic        Ready,
  output logic        RValid,
  output logic [31:0] RData,
  output logic        Err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DM_WAIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_r;
  logic             req_we_r;
  logic [31:0]      req_addr_r;
  logic [31:0]      req_wdata_r;
  logic [1:0]       req_size_r;
  logic             req_uns_r;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif

  state_t            state_r;
  logic [31:0]       mem_r [DEPTH];

  logic              accept_s;
  logic              respond_s;
  logic              commit_s;
  logic              op_we_s;
  logic [31:0]       op_addr_s;
  logic [31:0]       op_wdata_s;
  logic [1:0]        op_size_s;
  logic              op_uns_s;
  logic              op_err_s;
  logic [IDX_W-1:0]  idx_s;
  logic [31:0]       word_s;

  function automatic logic access_err(input logic [31:0] addr, input logic [1:0] size);
    logic bad_s;
    case (size)
      2'd0:    bad_s = 1'b0;
      2'd1:    bad_s = addr[0];
      2'd2:    bad_s = (addr[1:0] != 2'd0);
      default: bad_s = 1'b1;
    endcase
    return bad_s | ({2'b00, addr[31:2]} >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [1:0] lo,
                                            input logic [1:0] size, input logic uns);
    logic [7:0]  b_s;
    logic [15:0] h_s;
    logic [31:0] res_s;
    case (lo)
      2'd0:    b_s = word[7:0];
      2'd1:    b_s = word[15:8];
      2'd2:    b_s = word[23:16];
      default: b_s = word[31:24];
    endcase
    h_s = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    res_s = uns ? {24'h000000, b_s} : {{24{b_s[7]}}, b_s};
      2'd1:    res_s = uns ? {16'h0000, h_s} : {{16{h_s[15]}}, h_s};
      2'd2:    res_s = word;
      default: res_s = 32'h00000000;
    endcase
    return res_s;
  endfunction

  function automatic logic [31:0] store_lane(input logic [31:0] word, input logic [1:0] lo,
                                             input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] res_s;
    res_s = word;
    case (size)
      2'd0: begin
        case (lo)
          2'd0:    res_s[7:0]   = wdata[7:0];
          2'd1:    res_s[15:8]  = wdata[7:0];
          2'd2:    res_s[23:16] = wdata[7:0];
          default: res_s[31:24] = wdata[7:0];
        endcase
      end
      2'd1: begin
        if (lo[1]) res_s[31:16] = wdata[15:0];
        else       res_s[15:0]  = wdata[15:0];
      end
      2'd2:    res_s = wdata;
      default: res_s = word;
    endcase
    return res_s;
  endfunction

  // Pick the operation being answered: live inputs at acceptance, the latched copy after waiting
  always_comb begin
    accept_s = Req && (state_r == IDLE);
`ifdef DM_WAIT_EN
    if (state_r == WAIT) begin
      respond_s  = (cnt_r == {CNT_W{1'b0}});
      op_we_s    = req_we_r;
      op_addr_s  = req_addr_r;
      op_wdata_s = req_wdata_r;
      op_size_s  = req_size_r;
      op_uns_s   = req_uns_r;
    end else begin
      respond_s  = accept_s && (WAIT_CYCLES == 0);
      op_we_s    = We;
      op_addr_s  = Addr;
      op_wdata_s = WData;
      op_size_s  = Size;
      op_uns_s   = Unsigned;
    end
`else
    respond_s  = accept_s;
    op_we_s    = We;
    op_addr_s  = Addr;
    op_wdata_s = WData;
    op_size_s  = Size;
    op_uns_s   = Unsigned;
`endif
    op_err_s = access_err(op_addr_s, op_size_s);
    idx_s    = op_addr_s[IDX_W+1:2];
    word_s   = op_err_s ? 32'h00000000 : mem_r[idx_s];
    commit_s = respond_s && op_we_s && !op_err_s;
  end

  // Handshake FSM with registered response outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
      Ready   <= 1'b1;
      RValid  <= 1'b0;
      RData   <= 32'h00000000;
      Err     <= 1'b0;
`ifdef DM_WAIT_EN
      cnt_r       <= {CNT_W{1'b0}};
      req_we_r    <= 1'b0;
      req_addr_r  <= 32'h00000000;
      req_wdata_r <= 32'h00000000;
      req_size_r  <= 2'd0;
      req_uns_r   <= 1'b0;
`endif
    end else begin
      RValid <= 1'b0;
      RData  <= 32'h00000000;
      Err    <= 1'b0;
      if (respond_s) begin
        state_r <= RESP;
        Ready   <= 1'b0;
        RValid  <= 1'b1;
        Err     <= op_err_s;
        RData   <= (op_err_s || op_we_s) ? 32'h00000000
                                          : load_lane(word_s, op_addr_s[1:0], op_size_s, op_uns_s);
      end else begin
        case (state_r)
`ifdef DM_WAIT_EN
          IDLE: begin
            if (accept_s) begin
              state_r     <= WAIT;
              Ready       <= 1'b0;
              cnt_r       <= CNT_W'(WAIT_CYCLES - 1);
              req_we_r    <= We;
              req_addr_r  <= Addr;
              req_wdata_r <= WData;
              req_size_r  <= Size;
              req_uns_r   <= Unsigned;
            end else begin
              state_r <= IDLE;
            end
          end
          WAIT: cnt_r <= cnt_r - CNT_W'(1);
`else
          IDLE: state_r <= IDLE;
`endif
          RESP: begin
            state_r <= IDLE;
            Ready   <= 1'b1;
          end
          default: begin
            state_r <= IDLE;
            Ready   <= 1'b1;
          end
        endcase
      end
    end
  end

  // Word array: cleared by reset, written only on the edge entering RESP, and reset wins
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 32'h00000000;
    end else if (commit_s) begin
      mem_r[idx_s] <= store_lane(word_s, op_addr_s[1:0], op_size_s, op_wdata_s);
    end
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 3072, meaning the number of 32-bit memory words (byte range 0x0000-0x2FFF).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of extra wait cycles per request when DM_WAIT_EN is defined.
REQ-003 Port Clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port Reset  input  1  is a synchronous, active-high reset.
REQ-005 Port Req  input  1  is the request strobe from the CPU initiator.
REQ-006 Port We  input  1  selects the operation: 1 = store, 0 = load.
REQ-007 Port Addr  input  32  is the byte address.
REQ-008 Port WData  input  32  is the store data, right-aligned.
REQ-009 Port Size  input  2  encodes access size: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-010 Port Unsigned  input  1  selects load extension: 1 = zero-extend, 0 = sign-extend.
REQ-011 Port Ready  output  1  is high when a request can be accepted.
REQ-012 Port RValid  output  1  is a one-cycle response strobe.
REQ-013 Port RData  output  32  is the load result, right-aligned and extended.
REQ-014 Port Err  output  1  is the error flag, valid only while RValid is high.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; Ready = (state == IDLE).
REQ-016 Acceptance SHALL occur on the edge where Req && Ready; the block latches We, Addr, WData, Size and Unsigned at that edge.
- Without DM_WAIT_EN: IDLE -> RESP.
- With DM_WAIT_EN: IDLE -> WAIT, stays WAIT_CYCLES cycles, -> RESP.
REQ-017 RESP SHALL last exactly one cycle, with RValid = 1, then return to IDLE; Req arriving in WAIT or RESP is ignored (not queued).
REQ-018 Minimum request spacing SHALL be two cycles without DM_WAIT_EN and 2 + WAIT_CYCLES cycles with it.
REQ-019 Loads SHALL select the lane from Addr[1:0] (byte) or Addr[1] (halfword) and extend it per Unsigned; word loads return the full word.
REQ-020 Stores SHALL update only the addressed byte or halfword lane, leave the other lanes unchanged, and commit on the edge entering RESP.
REQ-021 RData SHALL be 0 for store responses.
REQ-022 An error SHALL be flagged for any of:
- Size == 3;
- halfword access with Addr[0] != 0;
- word access with Addr[1:0] != 0;
- Addr >= 4*DEPTH.
REQ-023 On an error the block SHALL respond with RValid = 1, Err = 1, RData = 0, and memory unchanged.
REQ-024 RData and Err SHALL be 0 whenever RValid = 0.
REQ-025 A load issued after a store to the same word SHALL return the updated data.

Reset
REQ-026 On a rising edge with Reset = 1, the block SHALL enter IDLE and set RValid = 0, RData = 0, Err = 0 and all memory words to 0; Ready = 1 in the following cycle.
REQ-027 Reset SHALL take priority over every other event; a request pending in WAIT or RESP is dropped without a response.
REQ-028 A store whose commit edge coincides with Reset = 1 SHALL NOT be written.

Configuration
REQ-029 Macro DM_WAIT_EN SHALL control wait-state insertion.
- Defined: the WAIT state is present and the response arrives 1 + WAIT_CYCLES cycles after acceptance.
- Undefined: the WAIT state and its counter are absent, the response arrives 1 cycle after acceptance, and WAIT_CYCLES is ignored.

Verification
REQ-030 Reset, then store word 0x12345678 to 0x0004, then word load from 0x0004 -> RData = 0x12345678, Err = 0, RValid high for exactly one cycle.
REQ-031 Byte store 0xAB to 0x0006, then:
- signed byte load from 0x0006 -> RData = 0xFFFFFFAB;
- unsigned halfword load from 0x0006 -> RData = 0x000012AB;
- word load from 0x0004 -> RData = 0x12AB5678.
REQ-032 Error responses, each with RData = 0 and memory unchanged:
- word load from 0x0002 -> Err = 1;
- store to 0x3000 -> Err = 1;
- Size = 3 -> Err = 1.
REQ-033 With DM_WAIT_EN and WAIT_CYCLES = 2, request accepted at cycle 0 -> RValid at cycle 3; Ready low in cycles 1-3; Req held high during cycles 1-3 is not accepted until Ready returns.
REQ-034 Reset asserted in the WAIT cycle of a store of 0xDEADBEEF to 0x0010 -> no RValid, Ready = 1 the next cycle, and a load from 0x0010 returns 0x00000000.
